// File: rtl/mem_access_unit.sv
// Single-port RAM access sequencer: latches a load/store request, checks alignment,
// drives byte-lane enables and shifted data for WAIT_STATES+1 cycles, then acks or errors.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    write,
  input  logic [1:0]              size,
  input  logic                    signed_ld,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ack,
  output logic                    busy,
  output logic                    err,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_oe,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffWidth = $clog2(NumBytes);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    accept;
  logic                    misaligned;
  logic                    too_wide;
  logic                    illegal;
  logic                    in_access;
  logic                    load_done;
  logic [OffWidth-1:0]     off;
  logic [OffWidth+2:0]     bit_off;
  logic [7:0]              be_ones;
  logic [DATA_WIDTH-1:0]   rd_shifted;
  logic [DATA_WIDTH-1:0]   rd_mask;
  logic                    rd_sign;
  logic [DATA_WIDTH-1:0]   rd_ext;

  assign accept = (state_q == StIdle) && req;

  // Legality is judged on the live request so the IDLE decision needs no extra cycle.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
  end

  assign too_wide = 32'(size) > OffWidth;
  assign illegal  = misaligned || too_wide;

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      write_q  <= write;
      size_q   <= size;
      signed_q <= signed_ld;
      addr_q   <= addr;
      wdata_q  <= wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (illegal) begin
            state_d = StError;
          end else begin
            state_d = StAccess;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign off       = addr_q[OffWidth-1:0];
  assign bit_off   = {off, 3'b000};
  assign in_access = (state_q == StAccess);
  assign load_done = in_access && (cnt_q == 4'd0) && !write_q;

  // Load extraction: move the addressed lane down, keep 8*2^size bits, extend.
  assign rd_shifted = mem_rdata >> bit_off;

  always_comb begin
    rd_mask = '1;
    rd_sign = 1'b0;
    case (size_q)
      2'b00: begin
        rd_mask = DATA_WIDTH'(8'hFF);
        rd_sign = rd_shifted[7];
      end
      2'b01: begin
        rd_mask = DATA_WIDTH'(16'hFFFF);
        rd_sign = rd_shifted[15];
      end
      2'b10: begin
        rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        rd_sign = rd_shifted[31];
      end
      default: begin
        rd_mask = '1;
        rd_sign = rd_shifted[DATA_WIDTH-1];
      end
    endcase
  end

  assign rd_ext  = (rd_shifted & rd_mask) | ((signed_q && rd_sign) ? ~rd_mask : '0);
  assign rdata_d = load_done ? rd_ext : rdata_q;

  always_comb begin
    be_ones = 8'h00;
    case (size_q)
      2'b00:   be_ones = 8'h01;
      2'b01:   be_ones = 8'h03;
      2'b10:   be_ones = 8'h0F;
      default: be_ones = 8'hFF;
    endcase
  end

  // Every output decodes from registered state; req never reaches the RAM side directly.
  assign rdata     = rdata_q;
  assign ack       = (state_q == StDone);
  assign err       = (state_q == StError);
  assign busy      = (state_q != StIdle);
  assign mem_cs    = in_access;
  assign mem_we    = in_access && write_q;
  assign mem_oe    = in_access && !write_q;
  assign mem_be    = in_access ? (be_ones[NumBytes-1:0] << off) : '0;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:OffWidth], {OffWidth{1'b0}}};
  assign mem_wdata = wdata_q << bit_off;

endmodule
